spi_arbiter: RTL and testbench

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_pkg.sv | 10 +
 rtl/spi_arbiter_if.sv | 26 ++
 rtl/spi_arbiter_rr.sv | 25 ++
 rtl/spi_arbiter.sv | 77 +++++++
 tb/tb_spi_arbiter.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared constants for the SPI arbiter (FSM encoding, byte width, default divider)
package spi_pkg;
  localparam int DATA_W = 8;
  localparam int DEF_CLK_DIV = 2;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
endpackage

// File: rtl/spi_arbiter_if.sv
// spi_arbiter_if: requester handshake, response and SPI pin bundle
interface spi_arbiter_if #(
  parameter int NUM_REQ = 3
);
  import spi_pkg::*;
  localparam int ID_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0] req_ready;
  logic rsp_valid;
  logic [ID_W-1:0] rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic sclk;
  logic [NUM_REQ-1:0] cs_n;
  logic mosi;
  logic miso;
  logic busy;
  modport master (
    input  req_valid, req_data, miso,
    output req_ready, rsp_valid, rsp_id, rsp_data, sclk, cs_n, mosi, busy
  );
  modport slave (
    output req_valid, req_data, miso,
    input  req_ready, rsp_valid, rsp_id, rsp_data, sclk, cs_n, mosi, busy
  );
endinterface

// File: rtl/spi_arbiter_rr.sv
// rr_arbiter: round-robin pick of the first active request after last_grant, with wrap
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  localparam int ID_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);
  int idx;
  // walk from the farthest candidate back to the nearest so the nearest active one wins
  always_comb begin
    grant = '0;
    grant_idx = '0;
    idx = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (req[idx]) begin
        grant = NUM_REQ'(1) << idx;
        grant_idx = ID_W'(idx);
      end
    end
  end
endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin shares one mode-0 SPI master among NUM_REQ requesters
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input logic clk,
  input logic reset,
  spi_arbiter_if.master bus
);
  localparam int ID_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  logic [2:0] state;
  logic [7:0] cnt;
  logic [3:0] phase;
  logic [ID_W-1:0] last_grant, gidx, rsp_id_q;
  logic [NUM_REQ-1:0] grant;
  logic [DATA_W-1:0] tx, rx, rsp_data_q;
  logic half_end, active;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req(bus.req_valid),
    .last_grant(last_grant),
    .grant(grant),
    .grant_idx(gidx)
  );
  assign half_end = cnt == 8'(CLK_DIV - 1);
  assign active = state == ST_SETUP || state == ST_SHIFT || state == ST_HOLD;
  assign bus.req_ready = (state == ST_IDLE && reset) ? grant : '0;
  assign bus.busy = state != ST_IDLE;
  assign bus.sclk = state == ST_SHIFT && phase[0];
  assign bus.cs_n = active ? ~(NUM_REQ'(1) << last_grant) : '1;
  assign bus.mosi = active & tx[DATA_W-1];
  assign bus.rsp_valid = state == ST_DONE;
  assign bus.rsp_id = rsp_id_q;
  assign bus.rsp_data = rsp_data_q;
  // transfer sequencer: even phases are sclk-low halves, odd phases sclk-high halves
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt <= '0;
      phase <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      tx <= '0;
      rx <= '0;
      rsp_data_q <= '0;
      rsp_id_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (|grant) begin
          state <= ST_SETUP;
          last_grant <= gidx;
          tx <= bus.req_data[gidx*DATA_W +: DATA_W];
          cnt <= '0;
        end
        ST_SETUP: if (half_end) begin
          state <= ST_SHIFT;
          cnt <= '0;
          phase <= '0;
        end else cnt <= cnt + 8'd1;
        ST_SHIFT: if (half_end) begin
          cnt <= '0;
          phase <= phase + 4'd1;
          if (!phase[0]) rx <= {rx[DATA_W-2:0], bus.miso};
          else tx <= {tx[DATA_W-2:0], 1'b0};
          if (phase == 4'd15) state <= ST_HOLD;
        end else cnt <= cnt + 8'd1;
        ST_HOLD: if (half_end) begin
          state <= ST_DONE;
          cnt <= '0;
          rsp_data_q <= rx;
          rsp_id_q <= last_grant;
        end else cnt <= cnt + 8'd1;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: vector table, corner sequences and random traffic against a round-robin/loopback model
module tb_spi_arbiter;
  typedef struct {
    logic [2:0]  v;
    logic [23:0] d;
    int          m;
    logic [2:0]  after;
    int          eid;
    logic [7:0]  edata;
  } vec_t;
  logic clk = 0;
  logic reset = 0;
  int mode = 0;
  int n_chk = 0;
  int n_fail = 0;
  vec_t tbl[10];
  spi_arbiter_if #(.NUM_REQ(3)) bus();
  spi_arbiter #(.NUM_REQ(3), .CLK_DIV(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign bus.miso = mode == 0 ? bus.mosi : mode == 1;
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask
  function automatic int onehot_idx(input logic [2:0] g);
    return g == 3'b001 ? 0 : g == 3'b010 ? 1 : g == 3'b100 ? 2 : -1;
  endfunction
  function automatic int model_grant(input int last, input logic [2:0] v);
    for (int k = 1; k <= 3; k++) if (v[(last + k) % 3]) return (last + k) % 3;
    return -1;
  endfunction
  task automatic xfer(input string name, input logic [2:0] v, input logic [23:0] d, input int m,
                      input logic [2:0] after, input int eid, input logic [7:0] edata);
    int gid, lat, rises;
    logic prev, multi, stray;
    logic [2:0] cs_and, exp_cs;
    @(posedge clk);
    #1;
    bus.req_valid = v;
    bus.req_data = d;
    mode = m;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (|bus.req_ready) break;
    end
    gid = onehot_idx(bus.req_ready);
    chk({name, " grant"}, gid, eid);
    @(posedge clk);
    #1;
    bus.req_valid = after;
    lat = -1;
    rises = 0;
    prev = 0;
    multi = 0;
    stray = 0;
    cs_and = '1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (bus.sclk && !prev) rises++;
      prev = bus.sclk;
      if ($countones(~bus.cs_n) > 1) multi = 1;
      if (bus.req_ready != 0) stray = 1;
      cs_and &= bus.cs_n;
      if (bus.rsp_valid) begin
        lat = n;
        break;
      end
    end
    exp_cs = ~(3'b001 << eid);
    chk({name, " latency"}, lat, 37);
    chk({name, " rsp_id"}, int'(bus.rsp_id), eid);
    chk({name, " rsp_data"}, int'(bus.rsp_data), int'(edata));
    chk({name, " sclk_rises"}, rises, 8);
    chk({name, " cs_n_low"}, int'(cs_and), int'(exp_cs));
    chk({name, " cs_n_multi"}, int'(multi), 0);
    chk({name, " ready_while_busy"}, int'(stray), 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int rises, last, g, m;
    logic prev, seen;
    logic [2:0] v, noise;
    logic [23:0] d;
    logic [7:0] eb;
    tbl[0] = '{3'b111, 24'h33F0AA, 0, 3'b110, 0, 8'hAA};
    tbl[1] = '{3'b110, 24'h33F0AA, 0, 3'b100, 1, 8'hF0};
    tbl[2] = '{3'b100, 24'h33F0AA, 0, 3'b000, 2, 8'h33};
    tbl[3] = '{3'b001, 24'h0000AA, 0, 3'b000, 0, 8'hAA};
    tbl[4] = '{3'b010, 24'h005A00, 0, 3'b000, 1, 8'h5A};
    tbl[5] = '{3'b101, 24'hC3003C, 0, 3'b001, 2, 8'hC3};
    tbl[6] = '{3'b001, 24'hC3003C, 0, 3'b000, 0, 8'h3C};
    tbl[7] = '{3'b010, 24'h000000, 1, 3'b000, 1, 8'hFF};
    tbl[8] = '{3'b100, 24'hFF0000, 2, 3'b000, 2, 8'h00};
    tbl[9] = '{3'b001, 24'h000096, 0, 3'b000, 0, 8'h96};
    bus.req_valid = 3'b111;
    bus.req_data = 24'h123456;
    #12;
    chk("reset req_ready", int'(bus.req_ready), 0);
    chk("reset cs_n", int'(bus.cs_n), 7);
    chk("reset sclk", int'(bus.sclk), 0);
    chk("reset mosi", int'(bus.mosi), 0);
    chk("reset rsp_valid", int'(bus.rsp_valid), 0);
    chk("reset rsp_data", int'(bus.rsp_data), 0);
    chk("reset rsp_id", int'(bus.rsp_id), 0);
    chk("reset busy", int'(bus.busy), 0);
    bus.req_valid = '0;
    @(posedge clk);
    #1;
    reset = 1;
    for (int i = 0; i < 10; i++)
      xfer($sformatf("vec%0d", i), tbl[i].v, tbl[i].d, tbl[i].m, tbl[i].after, tbl[i].eid, tbl[i].edata);
    repeat (3) @(negedge clk);
    chk("hold rsp_valid", int'(bus.rsp_valid), 0);
    chk("hold rsp_id", int'(bus.rsp_id), 0);
    chk("hold rsp_data", int'(bus.rsp_data), 8'h96);
    @(posedge clk);
    #1;
    bus.req_valid = 3'b001;
    bus.req_data = 24'h0000AA;
    mode = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (|bus.req_ready) break;
    end
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    rises = 0;
    prev = 0;
    for (int n = 0; n < 100 && rises < 3; n++) begin
      @(negedge clk);
      if (bus.sclk && !prev) rises++;
      prev = bus.sclk;
    end
    chk("abort sclk_rises", rises, 3);
    #2;
    reset = 0;
    #1;
    chk("abort cs_n", int'(bus.cs_n), 7);
    chk("abort sclk", int'(bus.sclk), 0);
    chk("abort busy", int'(bus.busy), 0);
    chk("abort mosi", int'(bus.mosi), 0);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1;
    end
    @(posedge clk);
    #1;
    reset = 1;
    repeat (45) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1;
    end
    chk("abort no_rsp", int'(seen), 0);
    xfer("post_abort", 3'b100, 24'h330000, 0, 3'b000, 2, 8'h33);
    xfer("pre_reset", 3'b001, 24'h0000AA, 0, 3'b000, 0, 8'hAA);
    @(posedge clk);
    #1;
    reset = 0;
    @(posedge clk);
    #1;
    reset = 1;
    xfer("favour0", 3'b011, 24'h00817E, 0, 3'b000, 0, 8'h7E);
    last = 0;
    eb = 8'h7E;
    for (int i = 0; i < 20; i++) begin
      v = 3'($urandom_range(1, 7));
      d = 24'($urandom);
      m = $urandom_range(0, 2);
      noise = 3'($urandom);
      g = model_grant(last, v);
      eb = m == 0 ? d[g*8 +: 8] : m == 1 ? 8'hFF : 8'h00;
      xfer($sformatf("rand%0d", i), v, d, m, noise, g, eb);
      last = g;
    end
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    repeat (3) @(negedge clk);
    chk("rand hold rsp_id", int'(bus.rsp_id), last);
    chk("rand hold rsp_data", int'(bus.rsp_data), int'(eb));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
